// File: rtl/pll_cntr_pkg.sv
// pll_cntr_pkg: types and defaults shared by the PLL scale-counter blocks.
//   mode_e  - recovered counter mode, shared with the scale-counter model
//   state_e - period-measurement FSM states of scale_cntr_decoder
//   CNT_W_DEF - default width of high/low fields and half-period counters
package pll_cntr_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_EVEN   = 2'd2,
        MODE_ODD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/scale_cntr_decoder_if.sv
// scale_cntr_decoder_if: measurement bus of the scale-counter decoder.
//   div_in     - divided counter output under measurement
//   high/low   - recovered high/low counts
//   mode       - recovered mode (OFF/BYPASS/EVEN/ODD)
//   meas_valid - one-cycle pulse when high/low/mode update
//   locked     - enough consecutive identical measurements seen
//   err        - sticky saturation / odd-period error
// master drives div_in and observes results; slave is the decoder.
interface scale_cntr_decoder_if
    import pll_cntr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();
    logic             div_in;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] low;
    mode_e            mode;
    logic             meas_valid;
    logic             locked;
    logic             err;

    modport master (output div_in, input high, low, mode, meas_valid, locked, err);
    modport slave  (input div_in, output high, low, mode, meas_valid, locked, err);
endinterface

// File: rtl/cntr_edge_det.sv
// cntr_edge_det: registers the measured input twice and flags its edges.
//   clk, reset - sampling clock, synchronous active-high reset
//   din        - input under measurement
//   s          - din registered once
//   rise, fall - single-cycle edge flags derived from s and its delayed copy
module cntr_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);
    logic s_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s   <= din;
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;
endmodule

// File: rtl/scale_cntr_decoder.sv
// scale_cntr_decoder: recovers high/low/mode settings of a PLL scale counter
// by timing the high and low phases of its divided output, where each clk
// edge is one VCO half-period.
//   clk, reset - sampling clock (2x VCO), synchronous active-high reset
//   bus        - slave side of scale_cntr_decoder_if (div_in in, results out)
module scale_cntr_decoder
    import pll_cntr_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TIMEOUT  = 1024,
    parameter int LOCK_CNT = 4
) (
    input logic                 clk,
    input logic                 reset,
    scale_cntr_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic s, rise, fall;

    cntr_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.div_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    state_e           state, state_nxt;
    logic [CNT_W-1:0] hcnt, lcnt, hcnt_nxt, lcnt_nxt;
    logic [CNT_W-1:0] hinc, linc;
    logic             eval, sat;
    logic [TW-1:0]    tcnt;
    logic             tmo_fire;
    logic [LW-1:0]    lock_cnt;

    logic [CNT_W-1:0] high_q, low_q;
    mode_e            mode_q;
    logic             meas_valid_q, err_q;

    assign hinc = hcnt + 1'b1;
    assign linc = lcnt + 1'b1;

    // Fires once when the edge-free run reaches TIMEOUT; the counter then
    // parks at TIMEOUT so it does not fire again.
    assign tmo_fire = ~(rise | fall) && (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        lcnt_nxt  = lcnt;
        eval      = 1'b0;
        sat       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                    hcnt_nxt  = CNT_W'(1);
                    lcnt_nxt  = '0;
                end
            end
            ST_HIGH: begin
                if (s) begin
                    if (&hinc) sat = 1'b1;
                    else       hcnt_nxt = hinc;
                end else if (fall) begin
                    state_nxt = ST_LOW;
                    lcnt_nxt  = CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (rise) begin
                    eval      = 1'b1;
                    state_nxt = ST_HIGH;
                    hcnt_nxt  = CNT_W'(1);
                    lcnt_nxt  = '0;
                end else if (&linc) begin
                    sat = 1'b1;
                end else begin
                    lcnt_nxt = linc;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A saturated phase is unmeasurable: pin the counters and wait for
        // a fresh rise.
        if (sat) begin
            state_nxt = ST_IDLE;
            hcnt_nxt  = (state == ST_HIGH) ? CNT_MAX : hcnt;
            lcnt_nxt  = (state == ST_LOW)  ? CNT_MAX : lcnt;
        end
        if (tmo_fire) state_nxt = ST_IDLE;
    end

    // Period evaluation. high = ceil(hcnt/2) covers both EVEN and ODD;
    // low is whatever remains of the half-period count P/2.
    logic [CNT_W:0]   per;
    logic [CNT_W-1:0] high_calc, low_calc;
    mode_e            mode_calc;
    logic             meas_ok, same;

    assign per       = {1'b0, hcnt} + {1'b0, lcnt};
    assign high_calc = (per == (CNT_W+1)'(2)) ? CNT_W'(1)
                     : (hcnt >> 1) + {{(CNT_W-1){1'b0}}, hcnt[0]};
    assign low_calc  = (per == (CNT_W+1)'(2)) ? '0 : per[CNT_W:1] - high_calc;
    assign mode_calc = (per == (CNT_W+1)'(2)) ? MODE_BYPASS
                     : (hcnt[0] ? MODE_ODD : MODE_EVEN);
    assign meas_ok   = eval & ~per[0];
    assign same      = (high_calc == high_q) && (low_calc == low_q) && (mode_calc == mode_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            hcnt         <= '0;
            lcnt         <= '0;
            tcnt         <= '0;
            lock_cnt     <= '0;
            high_q       <= '0;
            low_q        <= '0;
            mode_q       <= MODE_OFF;
            meas_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            hcnt         <= hcnt_nxt;
            lcnt         <= lcnt_nxt;
            meas_valid_q <= 1'b0;

            if (rise | fall)                tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT))  tcnt <= tcnt + 1'b1;

            if (tmo_fire) begin
                high_q       <= '0;
                low_q        <= '0;
                mode_q       <= MODE_OFF;
                meas_valid_q <= 1'b1;
                lock_cnt     <= '0;
            end else if (meas_ok) begin
                high_q       <= high_calc;
                low_q        <= low_calc;
                mode_q       <= mode_calc;
                meas_valid_q <= 1'b1;
                if (!same)                           lock_cnt <= LW'(1);
                else if (lock_cnt != LW'(LOCK_CNT))  lock_cnt <= lock_cnt + 1'b1;
            end

            if ((eval & per[0]) | sat) err_q <= 1'b1;
        end
    end

    assign bus.high       = high_q;
    assign bus.low        = low_q;
    assign bus.mode       = mode_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.locked     = (lock_cnt == LW'(LOCK_CNT));
    assign bus.err        = err_q;
endmodule

// File: tb/tb_scale_cntr_decoder.sv
// tb_scale_cntr_decoder: directed bench for scale_cntr_decoder. Each driven
// period pushes its expected result to a scoreboard; a monitor pops and
// compares whenever meas_valid pulses.
module tb_scale_cntr_decoder;
    import pll_cntr_pkg::*;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scale_cntr_decoder_if #(.CNT_W(CNT_W)) bus ();

    scale_cntr_decoder #(.CNT_W(CNT_W), .TIMEOUT(1024), .LOCK_CNT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] low;
        mode_e            mode;
        logic             locked;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            bus.div_in = v;
        end
    endtask

    task automatic push(input logic [CNT_W-1:0] eh, input logic [CNT_W-1:0] el,
                        input mode_e em, input logic elk);
        exp_t e;
        e.high = eh; e.low = el; e.mode = em; e.locked = elk;
        sb.push_back(e);
    endtask

    // One full period with a measurement expected when the next rise ends it.
    task automatic period(input int h, input int l, input logic [CNT_W-1:0] eh,
                          input logic [CNT_W-1:0] el, input mode_e em, input logic elk);
        push(eh, el, em, elk);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.meas_valid === 1'b1) begin
            check("meas_valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("meas_high",   32'(bus.high),   32'(e.high));
                check("meas_low",    32'(bus.low),    32'(e.low));
                check("meas_mode",   32'(bus.mode),   32'(e.mode));
                check("meas_locked", 32'(bus.locked), 32'(e.locked));
            end
        end
    end

    initial begin
        bus.div_in = 1'b0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_high",       32'(bus.high),       32'd0);
        check("rst_low",        32'(bus.low),        32'd0);
        check("rst_mode",       32'(bus.mode),       32'(MODE_OFF));
        check("rst_meas_valid", 32'(bus.meas_valid), 32'd0);
        check("rst_locked",     32'(bus.locked),     32'd0);
        check("rst_err",        32'(bus.err),        32'd0);
        reset = 1'b0;

        // EVEN 6/4 -> high 3 low 2, lock on the 4th
        for (int i = 0; i < 5; i++) period(6, 4, 16'd3, 16'd2, MODE_EVEN, i >= 3);
        // switch to 4/4: first new measurement drops lock, 4th re-locks
        for (int i = 0; i < 5; i++) period(4, 4, 16'd2, 16'd2, MODE_EVEN, i >= 3);
        check("locked_after_relock", 32'(bus.locked), 32'd1);

        // closing rise, then stuck low -> single OFF report
        drive(1'b1, 6);
        push('0, '0, MODE_OFF, 1'b0);
        drive(1'b0, 1200);
        check("timeout_locked", 32'(bus.locked), 32'd0);
        check("timeout_mode",   32'(bus.mode),   32'(MODE_OFF));
        check("timeout_drained", 32'(sb.size()), 32'd0);

        // ODD 5/5 -> high 3 low 2
        for (int i = 0; i < 3; i++) period(5, 5, 16'd3, 16'd2, MODE_ODD, 1'b0);
        // toggling every cycle -> BYPASS
        for (int i = 0; i < 5; i++) period(1, 1, 16'd1, 16'd0, MODE_BYPASS, i >= 3);
        drive(1'b1, 4);

        // reset in the middle of a high phase: partial period discarded
        check("pre_reset_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        reset      = 1'b1;
        bus.div_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("mid_reset_err",    32'(bus.err),    32'd0);
        check("mid_reset_locked", 32'(bus.locked), 32'd0);

        // 3/4 periods (odd total) -> no measurement, err set
        drive(1'b1, 3); drive(1'b0, 4);
        drive(1'b1, 3); drive(1'b0, 4);
        check("odd_period_err", 32'(bus.err), 32'd1);
        for (int i = 0; i < 2; i++) period(6, 4, 16'd3, 16'd2, MODE_EVEN, 1'b0);
        drive(1'b1, 3);
        repeat (3) @(negedge clk);
        check("err_sticky",   32'(bus.err),    32'd1);
        check("odd_drained",  32'(sb.size()),  32'd0);

        // only reset clears err
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("final_err",  32'(bus.err),  32'd0);
        check("final_mode", 32'(bus.mode), 32'(MODE_OFF));
        check("final_high", 32'(bus.high), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scale_cntr_decoder.md
SCALE_CNTR_DECODER -- requirements
Module: scale_cntr_decoder

Interface
REQ-001 Parameter CNT_W, default 16: width of high/low result fields and half-period counters.
REQ-002 Parameter TIMEOUT, default 1024: cycles without a div_in edge before mode is reported OFF.
REQ-003 Parameter LOCK_CNT, default 4: consecutive identical measurements required to assert locked.
REQ-004 clk  input  1  sampling clock; one rising edge per VCO half-period (2x VCO rate).
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 div_in  input  1  divided counter output under measurement, synchronous to clk.
REQ-007 high  output  CNT_W  recovered high count.
REQ-008 low  output  CNT_W  recovered low count.
REQ-009 mode  output  2  recovered mode: 0 OFF, 1 BYPASS, 2 EVEN, 3 ODD.
REQ-010 meas_valid  output  1  one-cycle pulse; high/low/mode updated this cycle.
REQ-011 locked  output  1  LOCK_CNT consecutive identical measurements seen.
REQ-012 err  output  1  sticky; counter saturation or odd total period; cleared by reset only.

Function
REQ-013 div_in registered into s, s registered into s_d; rise = s & ~s_d, fall = ~s & s_d.
REQ-014 FSM states: IDLE, HIGH, LOW.
REQ-015 IDLE: on rise -> HIGH, hcnt=1, lcnt=0; otherwise stay.
REQ-016 HIGH: s=1 -> hcnt+1; fall -> LOW, lcnt=1.
REQ-017 LOW: s=0 -> lcnt+1; rise -> evaluate measurement, then HIGH with hcnt=1, lcnt=0.
REQ-018 Evaluate: P = hcnt+lcnt (CNT_W+1 bits).
- P==2 -> BYPASS, high=1, low=0.
- P odd -> err=1, no update.
- hcnt even -> EVEN, high=hcnt/2.
- hcnt odd -> ODD, high=(hcnt+1)/2.
- low = P/2 - high.
REQ-019 meas_valid is asserted in the cycle after the rise that ends the period; outputs update in the same cycle.
REQ-020 hcnt or lcnt reaching all-ones -> saturate, err=1, discard period, return to IDLE.
REQ-021 Timeout counter clears on any rise or fall; on reaching TIMEOUT:
- mode=OFF, high=0, low=0, one meas_valid pulse;
- locked=0, lock counter=0;
- FSM -> IDLE.
- Counter then holds without re-pulsing.
REQ-022 Lock counter:
- increments on each valid measurement equal to the previous one (high, low, mode), saturating at LOCK_CNT;
- a differing measurement resets it to 1;
- locked = (counter==LOCK_CNT).
REQ-023 The first period after IDLE is measured normally; there is no discard of a partial first period, because IDLE waits for a rise.

Reset
REQ-024 Reset sets FSM=IDLE, hcnt=lcnt=0, timeout=0, lock counter=0, s=s_d=0, high=0, low=0, mode=OFF, meas_valid=0, locked=0, err=0.
REQ-025 Reset asserted mid-period discards the partial measurement; the next measurement starts at the first rise after reset release.

Structure
REQ-026 Package pll_cntr_pkg holds:
- the mode enum (OFF, BYPASS, EVEN, ODD), shared with the scale-counter model;
- default CNT_W.
REQ-027 Sub-module cntr_edge_det contains the s/s_d registers and the rise/fall outputs; the FSM, counters and result logic stay in the top module.

Verification
REQ-028 div_in EVEN, high=3, low=2 (6 cycles high, 4 low), 5 periods -> meas_valid each period, high=3, low=2, mode=2; locked from the 4th measurement.
REQ-029 div_in ODD, high=3, low=2 (5 high, 5 low) -> high=3, low=2, mode=3.
REQ-030 div_in toggling every cycle -> mode=1, high=1, low=0.
REQ-031 div_in stuck at 0 for 1024 cycles after lock -> one meas_valid with mode=0; locked=0.
REQ-032 Pattern changes from 6/4 to 4/4 after lock -> locked drops on the first 4/4 measurement and reasserts after 4; high=2, low=2, mode=2.
REQ-033 Reset pulsed mid-HIGH, and a 3-high/4-low pattern (odd total) -> no meas_valid for the partial period; err=1 on the odd period and it stays set until reset.
